// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared types, IO register addresses and address decode helper
// for the two-master IO bus arbiter.
// Contents: FSM state enum, 16-bit IO register offsets, io_addr_valid().
package io_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [15:0] IO_LED      = 16'hF000;
   localparam logic [15:0] IO_LED_REG0 = 16'hF004;
   localparam logic [15:0] IO_LED_REG1 = 16'hF008;
   localparam logic [15:0] IO_NUM      = 16'hF010;
   localparam logic [15:0] IO_TIMER    = 16'hE000;

   // Only the low 16 address bits select an IO register; upper bits are don't-care.
   function automatic logic io_addr_valid(input logic [15:0] a);
      return (a == IO_LED) || (a == IO_LED_REG0) || (a == IO_LED_REG1) ||
             (a == IO_NUM) || (a == IO_TIMER);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-input round-robin pick.
// Ports: req[1:0] requests, last = most recent winner id,
//        gnt_id = selected master, any = at least one request present.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_id,
   output logic       any
);

   always_comb begin
      any = |req;
      // On a tie the master that did not win last time goes next;
      // otherwise the lone requester (or 0 when idle) is picked.
      if (&req) begin
         gnt_id = ~last;
      end else begin
         gnt_id = req[1];
      end
   end

endmodule

// File: rtl/io_bus_arb.sv
// io_bus_arb: arbitrates CPU (m0) and debug (m1) masters onto the IO register bus,
// issuing one single-cycle io_ce strobe per valid transaction and returning
// rdata/err with a one-cycle rvalid pulse to the owning master.
// Ports: mN_req/we/addr/wdata in, mN_gnt/rvalid/rdata/err out (N=0,1);
//        io_ce/we/addr/din to decoder, io_dout from decoder; busy = FSM not IDLE.
module io_bus_arb
   import io_bus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic              io_ce,
   output logic              io_we,
   output logic [ADDR_W-1:0] io_addr,
   output logic [DATA_W-1:0] io_din,
   input  logic [DATA_W-1:0] io_dout,
   output logic              busy
);

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              owner_q, owner_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [1:0]        err_q, err_d;
   logic [DATA_W-1:0] rdata_q [2];
   logic [DATA_W-1:0] rdata_d [2];
   logic              io_ce_q, io_ce_d;
   logic              io_we_q, io_we_d;
   logic [ADDR_W-1:0] io_addr_q, io_addr_d;
   logic [DATA_W-1:0] io_din_q, io_din_d;

   logic              win_id;
   logic              win_any;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   rr_arb2 u_rr_arb2 (
      .req    ({m1_req, m0_req}),
      .last   (last_q),
      .gnt_id (win_id),
      .any    (win_any)
   );

   assign win_we    = win_id ? m1_we    : m0_we;
   assign win_addr  = win_id ? m1_addr  : m0_addr;
   assign win_wdata = win_id ? m1_wdata : m0_wdata;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      gnt_d      = 2'b00;
      rvalid_d   = 2'b00;
      err_d      = 2'b00;
      rdata_d[0] = rdata_q[0];
      rdata_d[1] = rdata_q[1];
      io_ce_d    = 1'b0;
      io_we_d    = 1'b0;
      io_addr_d  = io_addr_q;
      io_din_d   = io_din_q;

      case (state_q)
         ST_XFER: begin
            // Closing edge of the strobe cycle: decoder output is settled.
            state_d           = ST_RESP;
            rvalid_d[owner_q] = 1'b1;
            rdata_d[owner_q]  = io_we_q ? '0 : io_dout;
         end
         default: begin
            // IDLE and RESP arbitrate identically so back-to-back traffic
            // never has to pass through IDLE.
            state_d = ST_IDLE;
            if (win_any) begin
               last_d        = win_id;
               owner_d       = win_id;
               gnt_d[win_id] = 1'b1;
               if (io_addr_valid(win_addr[15:0])) begin
                  state_d   = ST_XFER;
                  io_ce_d   = 1'b1;
                  io_we_d   = win_we;
                  io_addr_d = win_addr;
                  io_din_d  = win_wdata;
               end else begin
                  // Bad address: never touch the bus, answer immediately.
                  state_d          = ST_RESP;
                  rvalid_d[win_id] = 1'b1;
                  err_d[win_id]    = 1'b1;
                  rdata_d[win_id]  = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         last_q     <= 1'b1;
         owner_q    <= 1'b0;
         gnt_q      <= 2'b00;
         rvalid_q   <= 2'b00;
         err_q      <= 2'b00;
         rdata_q[0] <= '0;
         rdata_q[1] <= '0;
         io_ce_q    <= 1'b0;
         io_we_q    <= 1'b0;
         io_addr_q  <= '0;
         io_din_q   <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         gnt_q      <= gnt_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         rdata_q[0] <= rdata_d[0];
         rdata_q[1] <= rdata_d[1];
         io_ce_q    <= io_ce_d;
         io_we_q    <= io_we_d;
         io_addr_q  <= io_addr_d;
         io_din_q   <= io_din_d;
      end
   end

   assign m0_gnt    = gnt_q[0];
   assign m1_gnt    = gnt_q[1];
   assign m0_rvalid = rvalid_q[0];
   assign m1_rvalid = rvalid_q[1];
   assign m0_err    = err_q[0];
   assign m1_err    = err_q[1];
   assign m0_rdata  = rdata_q[0];
   assign m1_rdata  = rdata_q[1];
   assign io_ce     = io_ce_q;
   assign io_we     = io_we_q;
   assign io_addr   = io_addr_q;
   assign io_din    = io_din_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_io_bus_arb.sv
// tb_io_bus_arb: directed-vector bench for io_bus_arb.
// Each scenario task drives stimulus and checks outputs 1 time unit after the rising edge.
// Prints one summary line at the end.
module tb_io_bus_arb;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        io_ce, io_we, busy;
   logic [31:0] io_addr, io_din, io_dout;

   int checks = 0;
   int errors = 0;

   io_bus_arb #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .io_ce(io_ce), .io_we(io_we), .io_addr(io_addr), .io_din(io_din),
      .io_dout(io_dout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #12;
      checks++; if ({io_ce, io_we, busy} !== 3'b000) begin errors++; $display("FAIL rst_ctrl got %b exp 000", {io_ce, io_we, busy}); end
      checks++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 6'b0) begin errors++; $display("FAIL rst_pulses got %b exp 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err}); end
      checks++; if ({io_addr, io_din} !== 64'h0) begin errors++; $display("FAIL rst_bus got %h %h exp 0 0", io_addr, io_din); end
      checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h %h exp 0 0", m0_rdata, m1_rdata); end
      step;
      rst = 1'b0;
   endtask

   // Both masters keep requesting from reset: grants 0,1,0,1 on odd cycles, rvalid on even.
   task automatic test_contention;
      int m;
      logic ce_exp, g0_exp, g1_exp, r0_exp, r1_exp;
      m0_we = 1'b1; m0_addr = 32'h0000_F000; m0_wdata = 32'h11;
      m1_we = 1'b0; m1_addr = 32'h0000_F004; io_dout = 32'hCAFE_0001;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step;
         ce_exp = (c % 2 == 1);
         m      = ce_exp ? ((c - 1) / 2) % 2 : ((c - 2) / 2) % 2;
         g0_exp = ce_exp && (m == 0);
         g1_exp = ce_exp && (m == 1);
         r0_exp = !ce_exp && (m == 0);
         r1_exp = !ce_exp && (m == 1);
         checks++; if (io_ce !== ce_exp) begin errors++; $display("FAIL cont_ce c%0d got %b exp %b", c, io_ce, ce_exp); end
         checks++; if ({m0_gnt, m1_gnt} !== {g0_exp, g1_exp}) begin errors++; $display("FAIL cont_gnt c%0d got %b exp %b", c, {m0_gnt, m1_gnt}, {g0_exp, g1_exp}); end
         checks++; if ({m0_rvalid, m1_rvalid} !== {r0_exp, r1_exp}) begin errors++; $display("FAIL cont_rvalid c%0d got %b exp %b", c, {m0_rvalid, m1_rvalid}, {r0_exp, r1_exp}); end
         if (c == 7) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
      checks++; if (m1_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL cont_rdata got %h exp cafe0001", m1_rdata); end
      step;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle busy got %b exp 0", busy); end
   endtask

   task automatic test_write;
      m0_we = 1'b1; m0_addr = 32'h0000_F000; m0_wdata = 32'h0000_00FF; m0_req = 1'b1;
      step;
      m0_req = 1'b0;
      checks++; if ({m0_gnt, io_ce, io_we, m1_gnt, busy} !== 5'b11101) begin errors++; $display("FAIL wr_c1 gnt/ce/we/m1gnt/busy got %b exp 11101", {m0_gnt, io_ce, io_we, m1_gnt, busy}); end
      checks++; if (io_addr !== 32'h0000_F000) begin errors++; $display("FAIL wr_addr got %h exp 0000f000", io_addr); end
      checks++; if (io_din !== 32'h0000_00FF) begin errors++; $display("FAIL wr_din got %h exp 000000ff", io_din); end
      step;
      checks++; if ({m0_rvalid, m0_err, m0_gnt, io_ce, m1_rvalid, m1_err} !== 6'b100000) begin errors++; $display("FAIL wr_c2 rv/err/gnt/ce/m1rv/m1err got %b exp 100000", {m0_rvalid, m0_err, m0_gnt, io_ce, m1_rvalid, m1_err}); end
      checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0", m0_rdata); end
      step;
      checks++; if ({busy, io_ce} !== 2'b00) begin errors++; $display("FAIL wr_c3 busy/ce got %b exp 00", {busy, io_ce}); end
      checks++; if (io_addr !== 32'h0000_F000) begin errors++; $display("FAIL wr_addr_hold got %h exp 0000f000", io_addr); end
   endtask

   task automatic test_read;
      m0_we = 1'b0; m0_addr = 32'h0000_F004; io_dout = 32'hAAAA_5555; m0_req = 1'b1;
      step;
      m0_req = 1'b0;
      checks++; if ({m0_gnt, io_ce, io_we} !== 3'b110) begin errors++; $display("FAIL rd0_c1 gnt/ce/we got %b exp 110", {m0_gnt, io_ce, io_we}); end
      step;
      checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL rd0_rvalid got %b exp 1", m0_rvalid); end
      checks++; if (m0_rdata !== 32'hAAAA_5555) begin errors++; $display("FAIL rd0_rdata got %h exp aaaa5555", m0_rdata); end
      // m1 request raised during RESP: granted back-to-back
      m1_we = 1'b0; m1_addr = 32'hABCD_E000; m1_req = 1'b1; io_dout = 32'h1234_5678;
      step;
      m1_req = 1'b0;
      checks++; if ({m1_gnt, m0_gnt, io_ce} !== 3'b101) begin errors++; $display("FAIL rd1_c1 m1gnt/m0gnt/ce got %b exp 101", {m1_gnt, m0_gnt, io_ce}); end
      checks++; if (io_addr !== 32'hABCD_E000) begin errors++; $display("FAIL rd1_addr got %h exp abcde000", io_addr); end
      step;
      checks++; if ({m1_rvalid, m1_err, m0_rvalid} !== 3'b100) begin errors++; $display("FAIL rd1_c2 rv/err/m0rv got %b exp 100", {m1_rvalid, m1_err, m0_rvalid}); end
      checks++; if (m1_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd1_rdata got %h exp 12345678", m1_rdata); end
      checks++; if (m0_rdata !== 32'hAAAA_5555) begin errors++; $display("FAIL rd1_m0_hold got %h exp aaaa5555", m0_rdata); end
      step;
   endtask

   task automatic test_error;
      int ce_seen = 0;
      m0_we = 1'b0; m0_addr = 32'h1234_F00C; m0_req = 1'b1;
      step;
      m0_req = 1'b0;
      ce_seen += int'(io_ce);
      checks++; if ({m0_gnt, m0_rvalid, m0_err, m1_gnt, busy} !== 5'b11101) begin errors++; $display("FAIL err_c1 gnt/rv/err/m1gnt/busy got %b exp 11101", {m0_gnt, m0_rvalid, m0_err, m1_gnt, busy}); end
      checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL err_rdata got %h exp 0", m0_rdata); end
      checks++; if (io_addr !== 32'hABCD_E000) begin errors++; $display("FAIL err_addr_hold got %h exp abcde000", io_addr); end
      step;
      ce_seen += int'(io_ce);
      checks++; if ({busy, m0_rvalid, m0_err} !== 3'b000) begin errors++; $display("FAIL err_c2 busy/rv/err got %b exp 000", {busy, m0_rvalid, m0_err}); end
      checks++; if (ce_seen !== 0) begin errors++; $display("FAIL err_no_ce got %0d exp 0", ce_seen); end
      // last is now 0, so m1 must win the tie
      m0_we = 1'b1; m0_addr = 32'h0000_F008; m1_we = 1'b1; m1_addr = 32'h0000_F010;
      m0_req = 1'b1; m1_req = 1'b1;
      step;
      m0_req = 1'b0; m1_req = 1'b0;
      checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL err_tie m0gnt/m1gnt got %b exp 01", {m0_gnt, m1_gnt}); end
      step;
      checks++; if (m1_rvalid !== 1'b1) begin errors++; $display("FAIL err_tie_rv got %b exp 1", m1_rvalid); end
      step;
   endtask

   task automatic test_back_to_back;
      int ce_cnt = 0;
      m0_we = 1'b1; m0_addr = 32'h0000_F008; m0_wdata = 32'h5; m0_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step;
         ce_cnt += int'(io_ce);
         if (c == 2) m0_req = 1'b0;
      end
      checks++; if (ce_cnt !== 1) begin errors++; $display("FAIL hold_drop_resp ce count got %0d exp 1", ce_cnt); end
      ce_cnt = 0;
      m0_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step;
         ce_cnt += int'(io_ce);
         if (c == 3) m0_req = 1'b0;
      end
      checks++; if (ce_cnt !== 2) begin errors++; $display("FAIL hold_extra ce count got %0d exp 2", ce_cnt); end
   endtask

   task automatic test_rst_mid;
      m0_we = 1'b1; m0_addr = 32'h0000_F010; m0_wdata = 32'h77; m0_req = 1'b1;
      step;
      checks++; if ({io_ce, m0_gnt} !== 2'b11) begin errors++; $display("FAIL rstm_pre ce/gnt got %b exp 11", {io_ce, m0_gnt}); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({io_ce, io_we, m0_gnt, busy} !== 4'b0000) begin errors++; $display("FAIL rstm_async ce/we/gnt/busy got %b exp 0000", {io_ce, io_we, m0_gnt, busy}); end
      checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL rstm_rdata got %h exp 0", m1_rdata); end
      m0_req = 1'b0;
      m1_we = 1'b0; m1_addr = 32'h0000_E000; m1_req = 1'b1; io_dout = 32'h0000_BEEF;
      @(posedge clk);
      #3 rst = 1'b0;
      checks++; if ({m0_rvalid, busy} !== 2'b00) begin errors++; $display("FAIL rstm_norv rv/busy got %b exp 00", {m0_rvalid, busy}); end
      step;
      m1_req = 1'b0;
      checks++; if ({m1_gnt, io_ce, m0_rvalid} !== 3'b110) begin errors++; $display("FAIL rstm_regrant m1gnt/ce/m0rv got %b exp 110", {m1_gnt, io_ce, m0_rvalid}); end
      step;
      checks++; if ({m1_rvalid, m0_rvalid} !== 2'b10) begin errors++; $display("FAIL rstm_rv m1rv/m0rv got %b exp 10", {m1_rvalid, m0_rvalid}); end
      checks++; if (m1_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL rstm_rdata_after got %h exp 0000beef", m1_rdata); end
      step;
   endtask

   initial begin
      rst = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
      io_dout = '0;
      test_reset;
      test_contention;
      test_write;
      test_read;
      test_error;
      test_back_to_back;
      test_rst_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
